// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: address type, fetch-address constants and the
// next-PC source encoding used by the fetch stage.
package cpu_defs_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic [WIDTH-1:0] addr_t;

  localparam addr_t RESET_ADDR = 32'h0000_3000;
  localparam addr_t EXC_ADDR   = 32'h0000_4180;
  localparam addr_t ADDR_MIN   = 32'h0000_3000;
  localparam addr_t ADDR_MAX   = 32'h0000_6ffc;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_SEQ   = 3'd1,
    SEL_PEND  = 3'd2,
    SEL_REDIR = 3'd3,
    SEL_ERET  = 3'd4,
    SEL_EXC   = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a branch/jump target that arrived while
// the fetch stage was stalled; a newer target replaces the held one.
module pc_redirect_buf
  import cpu_defs_pkg::*;
#(
  parameter int unsigned AW = WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          overwrite,
  input  logic          clear,
  input  logic [AW-1:0] target_in,
  output logic          valid,
  output logic [AW-1:0] target
);

  logic          valid_q, valid_d;
  logic [AW-1:0] target_q, target_d;

  // clear beats any write so an exception/eret in the same cycle discards the target
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load || overwrite) begin
      valid_d  = 1'b1;
      target_d = target_in;
    end else begin
      valid_d  = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised next-PC selection, PC register,
// stall-time redirect buffering and fetch-address legality check (AdEL).
module pc_gen #(
  parameter int unsigned      WIDTH      = cpu_defs_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(cpu_defs_pkg::RESET_ADDR),
  parameter logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(cpu_defs_pkg::EXC_ADDR),
  parameter int unsigned      STEP       = 4,
  parameter logic [WIDTH-1:0] ADDR_MIN   = WIDTH'(cpu_defs_pkg::ADDR_MIN),
  parameter logic [WIDTH-1:0] ADDR_MAX   = WIDTH'(cpu_defs_pkg::ADDR_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             adel,
  output logic             redirect_pending
);

  cpu_defs_pkg::pc_sel_e sel;
  logic [WIDTH-1:0]      pc_q, pc_d;
  logic                  buf_load, buf_overwrite, buf_clear, buf_valid;
  logic [WIDTH-1:0]      buf_target;
  logic                  below_min, above_max, misaligned;

  pc_redirect_buf #(
    .AW (WIDTH)
  ) u_redirect_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .overwrite (buf_overwrite),
    .clear     (buf_clear),
    .target_in (redirect_pc),
    .valid     (buf_valid),
    .target    (buf_target)
  );

  // Source priority: exc > eret > live redirect > buffered redirect > sequential > hold
  always_comb begin
    sel           = cpu_defs_pkg::SEL_HOLD;
    buf_load      = 1'b0;
    buf_overwrite = 1'b0;
    buf_clear     = 1'b0;
    if (exc_req) begin
      sel       = cpu_defs_pkg::SEL_EXC;
      buf_clear = 1'b1;
    end else if (eret_req) begin
      sel       = cpu_defs_pkg::SEL_ERET;
      buf_clear = 1'b1;
    end else if (redirect_valid && !stall) begin
      sel       = cpu_defs_pkg::SEL_REDIR;
      buf_clear = 1'b1;
    end else if (redirect_valid) begin
      buf_load      = !buf_valid;
      buf_overwrite = buf_valid;
    end else if (!stall && buf_valid) begin
      sel       = cpu_defs_pkg::SEL_PEND;
      buf_clear = 1'b1;
    end else if (!stall && fetch_valid && fetch_ready) begin
      sel = cpu_defs_pkg::SEL_SEQ;
    end else begin
      sel = cpu_defs_pkg::SEL_HOLD;
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      cpu_defs_pkg::SEL_EXC:   pc_d = EXC_ADDR;
      cpu_defs_pkg::SEL_ERET:  pc_d = epc;
      cpu_defs_pkg::SEL_REDIR: pc_d = redirect_pc;
      cpu_defs_pkg::SEL_PEND:  pc_d = buf_target;
      cpu_defs_pkg::SEL_SEQ:   pc_d = pc_q + WIDTH'(STEP);
      cpu_defs_pkg::SEL_HOLD:  pc_d = pc_q;
      default:                 pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Bounds at the edges of the address space would compare against a constant
  generate
    if (ADDR_MIN == '0) begin : g_no_min
      assign below_min = 1'b0;
    end else begin : g_min
      assign below_min = (pc_q < ADDR_MIN);
    end
    if (ADDR_MAX == '1) begin : g_no_max
      assign above_max = 1'b0;
    end else begin : g_max
      assign above_max = (pc_q > ADDR_MAX);
    end
  endgenerate

  assign misaligned       = (pc_q[1:0] != 2'b00);
  assign adel             = misaligned | below_min | above_max;
  assign fetch_valid      = ~adel;
  assign pc               = pc_q;
  assign redirect_pending = buf_valid;

endmodule
